chacha_poly_block_formatter: RTL and testbench

//  Upstream stage of the ChaCha20-Poly1305 MAC path. Takes one tagged byte-beat stream (AAD, then ciphertext).

---
 rtl/chacha_poly_pkg.sv | 44 ++++
 rtl/chacha_fmt_out_reg.sv | 64 ++++++
 rtl/chacha_poly_block_formatter.sv | 161 ++++++++++++++++
 tb/tb_chacha_poly_block_formatter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_poly_pkg.sv
// -----------------------------------------------------------------------------
// chacha_poly_pkg
// Shared definitions for the ChaCha20-Poly1305 MAC block formatter.
//   - State encoding, also used as the output-register port select
//   - BLK_BYTES: Poly1305 block size in bytes
//   - popcount16:   number of enabled bytes in a 16-bit keep vector
//   - keep_mask128: expands a 16-bit byte keep into a 128-bit bit mask
// No ports (package).
// -----------------------------------------------------------------------------
package chacha_poly_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_AAD  = 2'd1;
   localparam logic [1:0] ST_PLD  = 2'd2;
   localparam logic [1:0] ST_LEN  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      AAD  = ST_AAD,
      PLD  = ST_PLD,
      LEN  = ST_LEN
   } state_t;

   localparam int BLK_BYTES = 16;

   function automatic logic [4:0] popcount16(input logic [15:0] k);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < BLK_BYTES; i++) begin
         c = c + {4'd0, k[i]};
      end
      return c;
   endfunction

   function automatic logic [127:0] keep_mask128(input logic [15:0] k);
      logic [127:0] m;
      m = 128'd0;
      for (int i = 0; i < BLK_BYTES; i++) begin
         m[8*i +: 8] = {8{k[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/chacha_fmt_out_reg.sv
// -----------------------------------------------------------------------------
// chacha_fmt_out_reg
// One-entry valid/ready holding register shared by the AAD, payload and
// length output ports. load_sel (ST_AAD/ST_PLD/ST_LEN) picks which valid is
// raised; at most one valid is ever high.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load, load_sel           write the entry this cycle, target port
//   load_data, load_keep     entry contents
//   aad/pld/len_ready        downstream ready per port
//   aad/pld/len_valid        registered valids
//   data, keep               registered entry contents
//   can_load                 entry empty or draining this cycle
// -----------------------------------------------------------------------------
module chacha_fmt_out_reg
   import chacha_poly_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [1:0]   load_sel,
   input  logic [127:0] load_data,
   input  logic [15:0]  load_keep,
   input  logic         aad_ready,
   input  logic         pld_ready,
   input  logic         len_ready,
   output logic         aad_valid,
   output logic         pld_valid,
   output logic         len_valid,
   output logic [127:0] data,
   output logic [15:0]  keep,
   output logic         can_load
);

   logic fire;

   // Drain detection: a handshake on the active port frees the entry.
   always_comb begin
      fire     = (aad_valid & aad_ready) | (pld_valid & pld_ready) | (len_valid & len_ready);
      can_load = ~(aad_valid | pld_valid | len_valid) | fire;
   end

   // Entry register: load has priority over drain so back-to-back blocks flow without bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         aad_valid <= 1'b0;
         pld_valid <= 1'b0;
         len_valid <= 1'b0;
         data      <= 128'd0;
         keep      <= 16'd0;
      end else if (load) begin
         aad_valid <= (load_sel == ST_AAD);
         pld_valid <= (load_sel == ST_PLD);
         len_valid <= (load_sel == ST_LEN);
         data      <= load_data;
         keep      <= load_keep;
      end else if (fire) begin
         aad_valid <= 1'b0;
         pld_valid <= 1'b0;
         len_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/chacha_poly_block_formatter.sv
// -----------------------------------------------------------------------------
// chacha_poly_block_formatter
// Front end of the ChaCha20-Poly1305 MAC path. Takes a tagged byte-beat stream
// (AAD then ciphertext), zero-pads each beat to a full 16-byte block, counts
// bytes per segment and finally emits the 128-bit length block
// {pld_cnt, aad_cnt} (64-bit little-endian fields).
// Optional macro: CHACHA_FMT_LEN_CHECK_EN -- every valid beat is handshaked;
//   malformed or wrong-segment beats are dropped and raise sticky err.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   start                             begin a message (IDLE only)
//   in_valid/in_ready                 input handshake
//   in_data, in_keep, in_seg, in_last input beat, byte keep, segment, last
//   aad_valid/aad_data/aad_keep/aad_ready  padded AAD blocks
//   pld_valid/pld_data/pld_keep/pld_ready  padded payload blocks
//   len_valid/len_block/len_ready          length block
//   busy                              message in progress
//   err                               sticky protocol error (macro only)
// -----------------------------------------------------------------------------
module chacha_poly_block_formatter
   import chacha_poly_pkg::*;
#(
   parameter int LEN_W = 64
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         in_valid,
   input  logic [127:0] in_data,
   input  logic [15:0]  in_keep,
   input  logic         in_seg,
   input  logic         in_last,
   output logic         in_ready,
   output logic         aad_valid,
   output logic [127:0] aad_data,
   output logic [15:0]  aad_keep,
   input  logic         aad_ready,
   output logic         pld_valid,
   output logic [127:0] pld_data,
   output logic [15:0]  pld_keep,
   input  logic         pld_ready,
   output logic         len_valid,
   output logic [127:0] len_block,
   input  logic         len_ready,
   output logic         busy,
   output logic         err
);

   state_t             state, state_nx;
   logic [LEN_W-1:0]   aad_cnt, pld_cnt;
   logic               can_load, seg_match, flagged, accept, good;
   logic               beat_load, len_load, start_acc, len_hs;
   logic               load;
   logic [1:0]         load_sel;
   logic [127:0]       load_data;
   logic [127:0]       out_data;
   logic [15:0]        out_keep;

   // Beat qualification and output-register load selection.
   always_comb begin
      seg_match = ((state == AAD) && !in_seg) || ((state == PLD) && in_seg);
`ifdef CHACHA_FMT_LEN_CHECK_EN
      // Every beat in a segment state is taken; bad ones are discarded.
      in_ready  = ((state == AAD) || (state == PLD)) && can_load;
      flagged   = !seg_match
                  || (((in_keep + 16'd1) & in_keep) != 16'd0)
                  || (!in_last && (in_keep != 16'hFFFF));
`else
      // Wrong-segment beats stall until the state catches up.
      in_ready  = seg_match && can_load;
      flagged   = 1'b0;
`endif
      accept    = in_valid && in_ready;
      good      = accept && !flagged;
      beat_load = good && (in_keep != 16'd0);
      len_load  = (state == LEN) && !len_valid && can_load;
      start_acc = start && (state == IDLE);
      len_hs    = len_valid && len_ready;
      load      = beat_load || len_load;
      if (len_load) begin
         load_sel  = ST_LEN;
         load_data = {64'(pld_cnt), 64'(aad_cnt)};
      end else begin
         load_sel  = state;
         load_data = in_data & keep_mask128(in_keep);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start_acc) state_nx = AAD; else state_nx = IDLE;
         AAD:  if (good && in_last) state_nx = PLD; else state_nx = AAD;
         PLD:  if (good && in_last) state_nx = LEN; else state_nx = PLD;
         LEN:  if (len_hs) state_nx = IDLE; else state_nx = LEN;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Per-segment byte counters; wrap silently at 2^LEN_W.
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         aad_cnt <= '0;
         pld_cnt <= '0;
      end else if (beat_load && (state == AAD)) begin
         aad_cnt <= aad_cnt + LEN_W'(popcount16(in_keep));
      end else if (beat_load && (state == PLD)) begin
         pld_cnt <= pld_cnt + LEN_W'(popcount16(in_keep));
      end
   end

   // Busy flag: set on start acceptance, cleared by the length handshake.
   always_ff @(posedge clk) begin
      if (rst)            busy <= 1'b0;
      else if (start_acc) busy <= 1'b1;
      else if (len_hs)    busy <= 1'b0;
   end

`ifdef CHACHA_FMT_LEN_CHECK_EN
   // Sticky protocol error, cleared by the next accepted start.
   always_ff @(posedge clk) begin
      if (rst || start_acc)     err <= 1'b0;
      else if (accept && flagged) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

   chacha_fmt_out_reg u_out (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_sel  (load_sel),
      .load_data (load_data),
      .load_keep (16'hFFFF),
      .aad_ready (aad_ready),
      .pld_ready (pld_ready),
      .len_ready (len_ready),
      .aad_valid (aad_valid),
      .pld_valid (pld_valid),
      .len_valid (len_valid),
      .data      (out_data),
      .keep      (out_keep),
      .can_load  (can_load)
   );

   // The shared entry feeds all three data ports; valids say which is live.
   assign aad_data  = out_data;
   assign pld_data  = out_data;
   assign len_block = out_data;
   assign aad_keep  = out_keep;
   assign pld_keep  = out_keep;

endmodule

// File: tb/tb_chacha_poly_block_formatter.sv
// -----------------------------------------------------------------------------
// tb_chacha_poly_block_formatter
// Directed bench for chacha_poly_block_formatter. Optional section for
// CHACHA_FMT_LEN_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_chacha_poly_block_formatter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic [127:0] in_data = 128'd0;
   logic [15:0]  in_keep = 16'd0;
   logic         in_seg = 1'b0;
   logic         in_last = 1'b0;
   logic         in_ready;
   logic         aad_valid, pld_valid, len_valid;
   logic [127:0] aad_data, pld_data, len_block;
   logic [15:0]  aad_keep, pld_keep;
   logic         aad_ready = 1'b1;
   logic         pld_ready = 1'b1;
   logic         len_ready = 1'b1;
   logic         busy, err;

   int ncmp = 0;
   int nfail = 0;

   logic [127:0] aad_q[$];
   logic [15:0]  aad_keep_q[$];
   logic [127:0] pld_q[$];
   logic [127:0] blk;

   chacha_poly_block_formatter #(.LEN_W(64)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep),
      .in_seg(in_seg), .in_last(in_last), .in_ready(in_ready),
      .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_ready(aad_ready),
      .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_ready(pld_ready),
      .len_valid(len_valid), .len_block(len_block), .len_ready(len_ready),
      .busy(busy), .err(err)
   );

   initial forever #5 clk = ~clk;

   // Capture output blocks; inputs only change just after posedge, so the
   // negedge view equals what the next posedge sees.
   always @(negedge clk) begin
      if (aad_valid && aad_ready) begin
         aad_q.push_back(aad_data);
         aad_keep_q.push_back(aad_keep);
      end
      if (pld_valid && pld_ready) pld_q.push_back(pld_data);
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic seg, input logic [127:0] d, input logic [15:0] k, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1; in_seg = seg; in_data = d; in_keep = k; in_last = l;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", {127'd0, in_ready}, 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; in_keep = 16'd0;
   endtask

   task automatic wait_len(output logic [127:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!(len_valid && len_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("len_timeout", {127'd0, len_valid}, 128'd1);
      b = len_block;
      @(posedge clk); #1;
   endtask

   task automatic clear_q();
      aad_q.delete();
      aad_keep_q.delete();
      pld_q.delete();
   endtask

   initial begin
      // ---------------- reset ----------------
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy",      {127'd0, busy},      128'd0);
      chk("rst_in_ready",  {127'd0, in_ready},  128'd0);
      chk("rst_aad_valid", {127'd0, aad_valid}, 128'd0);
      chk("rst_pld_valid", {127'd0, pld_valid}, 128'd0);
      chk("rst_len_valid", {127'd0, len_valid}, 128'd0);
      chk("rst_err",       {127'd0, err},       128'd0);
      chk("rst_data",      len_block,           128'd0);
      chk("rst_keep",      {112'd0, pld_keep},  128'd0);
      @(posedge clk); #1;

      // ---------------- 1: AAD 12 B, PLD 16 + 5 B ----------------
      clear_q();
      do_start();
      @(negedge clk);
      chk("t1_busy", {127'd0, busy}, 128'd1);
      @(posedge clk); #1;
      send(1'b0, 128'hFFEEDDCC_BBAA9988_77665544_33221100, 16'h0FFF, 1'b1);
      start = 1'b1;                       // ignored while busy
      @(posedge clk); #1;
      start = 1'b0;
      send(1'b1, 128'h11111111_22222222_33333333_44444444, 16'hFFFF, 1'b0);
      send(1'b1, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'h001F, 1'b1);
      wait_len(blk);
      chk("t1_aad_n",    128'(aad_q.size()), 128'd1);
      chk("t1_aad_data", aad_q[0], 128'h00000000_BBAA9988_77665544_33221100);
      chk("t1_aad_keep", {112'd0, aad_keep_q[0]}, {112'd0, 16'hFFFF});
      chk("t1_pld_n",    128'(pld_q.size()), 128'd2);
      chk("t1_pld0",     pld_q[0], 128'h11111111_22222222_33333333_44444444);
      chk("t1_pld1",     pld_q[1], 128'h00000000_00000000_00000004_03020100);
      chk("t1_len",      blk, {64'd21, 64'd12});
      @(negedge clk);
      chk("t1_busy_end", {127'd0, busy}, 128'd0);
      @(posedge clk); #1;

      // ---------------- 2: empty AAD, PLD 32 B ----------------
      clear_q();
      do_start();
      send(1'b0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 16'h0000, 1'b1);
      send(1'b1, 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF, 16'hFFFF, 1'b0);
      send(1'b1, 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF, 16'hFFFF, 1'b1);
      wait_len(blk);
      chk("t2_aad_n", 128'(aad_q.size()), 128'd0);
      chk("t2_pld_n", 128'(pld_q.size()), 128'd2);
      chk("t2_pld1",  pld_q[1], 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF);
      chk("t2_len",   blk, {64'd32, 64'd0});

      // ---------------- 3: both segments empty ----------------
      clear_q();
      do_start();
`ifndef CHACHA_FMT_LEN_CHECK_EN
      // payload-tagged beat while in AAD must wait
      in_valid = 1'b1; in_seg = 1'b1; in_keep = 16'hFFFF;
      @(negedge clk);
      chk("t3_wrong_seg_ready", {127'd0, in_ready}, 128'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
`endif
      send(1'b0, 128'd0, 16'h0000, 1'b1);
      send(1'b1, 128'd0, 16'h0000, 1'b1);
      @(negedge clk);
      chk("t3_busy_pre", {127'd0, busy}, 128'd1);
      @(posedge clk); #1;
      wait_len(blk);
      chk("t3_len",   blk, 128'd0);
      chk("t3_aad_n", 128'(aad_q.size()), 128'd0);
      chk("t3_pld_n", 128'(pld_q.size()), 128'd0);
      @(negedge clk);
      chk("t3_busy_end", {127'd0, busy}, 128'd0);
      @(posedge clk); #1;

      // ---------------- 4: AAD backpressure ----------------
      clear_q();
      aad_ready = 1'b0;
      do_start();
      in_valid = 1'b1; in_seg = 1'b0; in_keep = 16'hFFFF; in_last = 1'b0;
      in_data = 128'hAAAA0000_AAAA1111_AAAA2222_AAAA3333;
      @(negedge clk);
      chk("t4_first_ready", {127'd0, in_ready}, 128'd1);
      @(posedge clk); #1;
      in_data = 128'hBBBB0000_BBBB1111_BBBB2222_BBBB3333; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_stall_ready", {127'd0, in_ready}, 128'd0);
         chk("t4_stall_data",  aad_data, 128'hAAAA0000_AAAA1111_AAAA2222_AAAA3333);
         @(posedge clk); #1;
      end
      aad_ready = 1'b1;
      @(negedge clk);
      chk("t4_release_ready", {127'd0, in_ready}, 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      send(1'b1, 128'd0, 16'h0000, 1'b1);
      wait_len(blk);
      chk("t4_aad_n", 128'(aad_q.size()), 128'd2);
      chk("t4_aad0",  aad_q[0], 128'hAAAA0000_AAAA1111_AAAA2222_AAAA3333);
      chk("t4_aad1",  aad_q[1], 128'hBBBB0000_BBBB1111_BBBB2222_BBBB3333);
      chk("t4_len",   blk, {64'd0, 64'd32});

      // ---------------- 5: reset with pending payload block ----------------
      clear_q();
      do_start();
      send(1'b0, 128'd0, 16'h0000, 1'b1);
      pld_ready = 1'b0;
      send(1'b1, 128'hCAFECAFE_CAFECAFE_CAFECAFE_CAFECAFE, 16'hFFFF, 1'b0);
      @(negedge clk);
      chk("t5_pending", {127'd0, pld_valid}, 128'd1);
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1;           // rst wins over start
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; pld_ready = 1'b1;
      @(negedge clk);
      chk("t5_pld_valid", {127'd0, pld_valid}, 128'd0);
      chk("t5_aad_valid", {127'd0, aad_valid}, 128'd0);
      chk("t5_len_valid", {127'd0, len_valid}, 128'd0);
      chk("t5_busy",      {127'd0, busy},      128'd0);
      chk("t5_in_ready",  {127'd0, in_ready},  128'd0);
      @(posedge clk); #1;
      do_start();
      send(1'b0, 128'h00000000_00000000_00000000_000000FF, 16'h0001, 1'b1);
      send(1'b1, 128'd0, 16'h0000, 1'b1);
      wait_len(blk);
      chk("t5_len",   blk, {64'd0, 64'd1});
      chk("t5_pld_n", 128'(pld_q.size()), 128'd0);

`ifdef CHACHA_FMT_LEN_CHECK_EN
      // ---------------- 6: malformed payload beat ----------------
      clear_q();
      do_start();
      send(1'b0, 128'd0, 16'h0000, 1'b1);
      send(1'b1, 128'h12345678_12345678_12345678_12345678, 16'h00FF, 1'b0);
      @(negedge clk);
      chk("t6_err",       {127'd0, err},       128'd1);
      chk("t6_pld_valid", {127'd0, pld_valid}, 128'd0);
      @(posedge clk); #1;
      send(1'b1, 128'h00000000_00000000_00000000_00ABCDEF, 16'h0007, 1'b1);
      wait_len(blk);
      chk("t6_len",      blk, {64'd3, 64'd0});
      chk("t6_pld_n",    128'(pld_q.size()), 128'd1);
      chk("t6_err_held", {127'd0, err}, 128'd1);
      do_start();
      @(negedge clk);
      chk("t6_err_clr", {127'd0, err}, 128'd0);
      @(posedge clk); #1;
      send(1'b0, 128'd0, 16'h0000, 1'b1);
      send(1'b1, 128'd0, 16'h0000, 1'b1);
      wait_len(blk);
      chk("t6_len2", blk, 128'd0);
`else
      chk("err_tied", {127'd0, err}, 128'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
